// File: rtl/iob_rr_arbiter_pkg.sv
// Shared definitions for the IOb round-robin arbiter: request/response widths,
// field positions inside the packed IOb native buses, and the FSM state encoding.
package iob_rr_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Request bus is {valid, addr, wdata, wstrb}; response bus is {rdata, ready}.
   function automatic int req_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w + data_w / 8;
   endfunction

   function automatic int resp_w(input int data_w);
      return data_w + 1;
   endfunction

   function automatic int wstrb_pos();
      return 0;
   endfunction

   function automatic int wdata_pos(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int addr_pos(input int data_w);
      return data_w / 8 + data_w;
   endfunction

   function automatic int valid_pos(input int addr_w, input int data_w);
      return data_w / 8 + data_w + addr_w;
   endfunction

   localparam int READY_POS = 0;
   localparam int RDATA_POS = 1;

endpackage

// File: rtl/iob_rr_prio_enc.sv
// Combinational round-robin priority encoder: returns the one-hot lowest
// requester at or after ptr_i, wrapping from N-1 back to 0.
module iob_rr_prio_enc #(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o
);

   logic [N-1:0]   mask;
   logic [2*N-1:0] dbl;

   // The masked copy sits in the low half so requesters at or after ptr win
   // first; the unmasked copy above it supplies the wrap-around candidates.
   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i >= int'(ptr_i));
      end
      dbl   = {req_i, req_i & mask};
      gnt_o = '0;
      for (int i = 2 * N - 1; i >= 0; i--) begin
         if (dbl[i]) begin
            gnt_o          = '0;
            gnt_o[i % N]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter sharing one IOb native slave port among N_MASTERS masters.
// One transaction in flight; grant is held from acceptance until the slave's ready.
module iob_rr_arbiter
   import iob_rr_arbiter_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   localparam int REQ_W    = req_w(ADDR_W, DATA_W),
   localparam int RESP_W   = resp_w(DATA_W)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_MASTERS*REQ_W-1:0]    m_req,
   output logic [N_MASTERS*RESP_W-1:0]   m_resp,
   output logic [REQ_W-1:0]              s_req,
   input  logic [RESP_W-1:0]             s_resp,
   output logic [N_MASTERS-1:0]          grant,
   output logic                          busy
);

   localparam int PTR_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int VALID  = valid_pos(ADDR_W, DATA_W);

   arb_state_e             state_q;
   logic [PTR_W-1:0]       ptr_q;
   logic [PTR_W-1:0]       gidx_q;
   logic [N_MASTERS-1:0]   grant_q;
   logic [N_MASTERS-1:0]   valid;
   logic [N_MASTERS-1:0]   winner;
   logic [PTR_W-1:0]       winIdx;
   logic [PTR_W-1:0]       nextPtr;

   always_comb begin
      for (int i = 0; i < N_MASTERS; i++) begin
         valid[i] = m_req[i*REQ_W + VALID];
      end
   end

   iob_rr_prio_enc #(
      .N     (N_MASTERS),
      .PTR_W (PTR_W)
   ) u_prio_enc (
      .req_i (valid),
      .ptr_i (ptr_q),
      .gnt_o (winner)
   );

   always_comb begin
      winIdx = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (winner[i]) winIdx = PTR_W'(i);
      end
   end

   assign nextPtr = (gidx_q == PTR_W'(N_MASTERS - 1)) ? '0 : gidx_q + 1'b1;

   // Ready arriving while IDLE is ignored, which also covers late responses after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         grant_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|valid) begin
                  state_q <= BUSY;
                  grant_q <= winner;
                  gidx_q  <= winIdx;
               end
            end
            BUSY: begin
               if (s_resp[READY_POS]) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  ptr_q   <= nextPtr;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // grant_q is zero while idle, so the OR-mux drives an all-zero slave request then.
   always_comb begin
      s_req = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (grant_q[i]) s_req = s_req | m_req[i*REQ_W +: REQ_W];
      end
   end

   always_comb begin
      m_resp = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         m_resp[i*RESP_W +: RESP_W] = {s_resp[RESP_W-1:RDATA_POS], s_resp[READY_POS] & grant_q[i]};
      end
   end

   assign grant = grant_q;
   assign busy  = (state_q == BUSY);

endmodule
